// File: rtl/alien_bombs_pkg.sv
// Shared types and geometry for the alien bomb engine.
package alien_bombs_pkg;

   localparam int unsigned SCREEN_W     = 10;
   localparam int unsigned EXT_W        = SCREEN_W + 1;
   localparam int unsigned BOMB_W_UNITS = 1;
   localparam int unsigned BOMB_H_UNITS = 3;

   typedef logic [SCREEN_W-1:0] coord_t;
   typedef logic [EXT_W-1:0]    ext_t;

   typedef struct packed {
      logic   active;
      logic   hit;
      coord_t x;
      coord_t y;
   } bomb_slot_t;

endpackage

// File: rtl/alien_bombs_bomb_slot.sv
// One bomb slot: position register, per-frame move/retire, rectangle test and sticky hit latch.
module alien_bombs_bomb_slot
   import alien_bombs_pkg::*;
#(
   parameter int unsigned LOWER_BORDER = 480,
   parameter int unsigned SCALING      = 4,
   parameter int unsigned BOMB_SPEED   = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick,
   input  logic                load,
   input  logic [SCREEN_W-1:0] load_x,
   input  logic [SCREEN_W-1:0] load_y,
   input  logic [SCREEN_W-1:0] hpos,
   input  logic [SCREEN_W-1:0] vpos,
   input  logic                cannon_gfx,
   output logic                active,
   output logic                hit,
   output logic                covers
);

   localparam int unsigned W_PX = SCALING * BOMB_W_UNITS;
   localparam int unsigned H_PX = SCALING * BOMB_H_UNITS;

   bomb_slot_t slot_q, slot_d;
   ext_t       x_ext, y_ext, h_ext, v_ext, x_end, y_end, y_next;
   logic       bottom, collide;

   // Extra bit keeps the bounds and the bottom test free of 10-bit wrap.
   assign x_ext  = {1'b0, slot_q.x};
   assign y_ext  = {1'b0, slot_q.y};
   assign h_ext  = {1'b0, hpos};
   assign v_ext  = {1'b0, vpos};
   assign x_end  = x_ext + ext_t'(W_PX);
   assign y_end  = y_ext + ext_t'(H_PX);
   assign y_next = y_ext + ext_t'(BOMB_SPEED);
   assign bottom = y_next > ext_t'(LOWER_BORDER);

   assign covers  = slot_q.active && (h_ext >= x_ext) && (h_ext < x_end)
                    && (v_ext >= y_ext) && (v_ext < y_end);
   assign collide = covers && cannon_gfx;

   always_comb begin
      slot_d = slot_q;
      if (tick) begin
         if (slot_q.active) begin
            if (slot_q.hit || bottom) begin
               slot_d.active = 1'b0;
               slot_d.hit    = 1'b0;
            end else begin
               slot_d.y   = y_next[SCREEN_W-1:0];
               // Overlap seen during the tick cycle is reported at the next tick.
               slot_d.hit = collide;
            end
         end
      end else if (load) begin
         slot_d.active = 1'b1;
         slot_d.hit    = 1'b0;
         slot_d.x      = load_x;
         slot_d.y      = load_y;
      end else if (collide) begin
         slot_d.hit = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign active = slot_q.active;
   assign hit    = slot_q.hit;

endmodule

// File: rtl/alien_bombs.sv
// Alien bomb engine: frame tick detect, drop cooldown, free-slot allocation and output merge.
module alien_bombs
   import alien_bombs_pkg::*;
#(
   parameter int unsigned NUM_BOMBS       = 3,
   parameter int unsigned LOWER_BORDER    = 480,
   parameter int unsigned SCALING         = 4,
   parameter int unsigned BOMB_SPEED      = 3,
   parameter int unsigned COOLDOWN_FRAMES = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 vsync,
   input  logic [SCREEN_W-1:0]  hpos,
   input  logic [SCREEN_W-1:0]  vpos,
   input  logic                 drop_req,
   input  logic [SCREEN_W-1:0]  drop_x,
   input  logic [SCREEN_W-1:0]  drop_y,
   output logic                 drop_ack,
   input  logic                 cannon_gfx,
   output logic                 cannon_hit,
   output logic                 bomb_gfx,
   output logic [NUM_BOMBS-1:0] bombs_active
);

   localparam int unsigned CD_W = $clog2(COOLDOWN_FRAMES + 1);

   logic                 vsync_q, tick, accept, drop_ack_q, found;
   logic [CD_W-1:0]      cooldown_q, cooldown_d;
   logic [NUM_BOMBS-1:0] active, hit, covers, load;

   assign tick   = vsync & ~vsync_q;
   assign accept = drop_req && !tick && (cooldown_q == '0) && !(&active);

   // Lowest-index free slot takes the drop.
   always_comb begin
      load  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_BOMBS; i++) begin
         if (!active[i] && !found) begin
            load[i] = accept;
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      cooldown_d = cooldown_q;
      if (tick) begin
         if (cooldown_q != '0) begin
            cooldown_d = cooldown_q - CD_W'(1);
         end
      end else if (accept) begin
         cooldown_d = CD_W'(COOLDOWN_FRAMES);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vsync_q    <= 1'b0;
         cooldown_q <= '0;
         drop_ack_q <= 1'b0;
      end else begin
         vsync_q    <= vsync;
         cooldown_q <= cooldown_d;
         drop_ack_q <= accept;
      end
   end

   for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_slot
      alien_bombs_bomb_slot #(
         .LOWER_BORDER (LOWER_BORDER),
         .SCALING      (SCALING),
         .BOMB_SPEED   (BOMB_SPEED)
      ) u_slot (
         .clk        (clk),
         .reset      (reset),
         .tick       (tick),
         .load       (load[g]),
         .load_x     (drop_x),
         .load_y     (drop_y),
         .hpos       (hpos),
         .vpos       (vpos),
         .cannon_gfx (cannon_gfx),
         .active     (active[g]),
         .hit        (hit[g]),
         .covers     (covers[g])
      );
   end

   assign drop_ack     = drop_ack_q;
   assign cannon_hit   = tick & (|hit);
   assign bomb_gfx     = |covers;
   assign bombs_active = active;

endmodule

// File: doc/alien_bombs.md
# alien_bombs

Alien-side projectile engine: the downward counterpart of the cannon laser. Holds up to NUM_BOMBS alien bombs, accepts drop requests from the alien formation, moves bombs down once per frame, detects pixel-level overlap with the cannon, and produces the bomb graphics bit for the video mixer. It sits between the alien formation logic (which picks the shooter), the cannon, and the pixel mixer.

## Interface
- NUM_BOMBS, 3: number of bomb slots (1..4)
- LOWER_BORDER, 480: bomb retires once its y would exceed this
- SCALING, 4: pixel scale; bomb is 1×3 units, so 4×12 px
- BOMB_SPEED, 3: pixels moved down per frame
- COOLDOWN_FRAMES, 20: minimum frames between accepted drops (≥1)

- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high; clears all state
- vsync  in  1  frame sync, level; frame tick = its rising edge detected on clk
- hpos, vpos  in  10 each  current beam position
- drop_req  in  1  formation requests a bomb; held until drop_ack
- drop_x, drop_y  in  10 each  spawn position (top-left of bomb), valid with drop_req
- drop_ack  out  1  one-clk pulse: request accepted into a slot
- cannon_gfx  in  1  cannon pixel active at (hpos, vpos)
- cannon_hit  out  1  one-clk pulse on frame tick when a bomb touched the cannon
- bomb_gfx  out  1  any active bomb covers (hpos, vpos)
- bombs_active  out  NUM_BOMBS  per-slot active flags

## Operation
- Per slot: active, x[9:0], y[9:0], hit flag. Reset: all 0; drop_ack=0, cannon_hit=0, bombs_active=0, cooldown=0, vsync_q=0.
- Frame tick: tick = vsync & ~vsync_q, vsync_q registered each clk.
- On tick, for each active slot: if hit flag → clear active and hit; else if y + BOMB_SPEED > LOWER_BORDER (11-bit compare, no wrap) → clear active; else y <= y + BOMB_SPEED. cooldown decrements if nonzero. cannon_hit pulses this cycle iff any slot had hit flag set.
- Drop accept (non-tick cycles only): drop_req && cooldown==0 && some slot free → load lowest-index free slot with drop_x/drop_y, set active, pulse drop_ack, cooldown <= COOLDOWN_FRAMES. Otherwise request stays pending; no ack.
- Collision: on every clk, if slot active and slot covers (hpos,vpos) and cannon_gfx → set that slot's hit flag (sticky until tick). Hit bombs still draw until retired.
- bomb_gfx combinational: OR over active slots of x ≤ hpos < x+SCALING and y ≤ vpos < y+3·SCALING, 11-bit arithmetic.

## Timing
- drop_ack: earliest one clk after drop_req rises, registered; a just-loaded slot is visible in bomb_gfx the next clk.
- Tick and drop_req in same cycle: tick processing only; drop accepted on a later cycle.
- Slot freed on tick is available from the next clk.
- cannon_hit latency: the first frame tick following the overlapping pixel.
- Reset asserted mid-frame: all slots cleared immediately; pending request is ignored until deassert, then handled normally.
- Hit detected during the tick cycle itself is applied at the following tick.

## Structure
- Shared package: SCREEN coordinate width (10), bomb width/height units, bomb_slot_t struct {active, hit, x, y}.
- One sub-module natural: bomb_slot (per-slot register, move/retire, rectangle test, collision latch); alien_bombs owns tick edge detect, cooldown counter, free-slot priority encoder, output ORs.

## Test plan
- Reset: reset high mid-operation → bombs_active=0, bomb_gfx=0, drop_ack=0 within same clk edge.
- Single drop: drop_req with (100,200), cooldown 0 → drop_ack one clk later, slot0 active; after 5 ticks y=215; bomb_gfx=1 at (103,226), 0 at (104,215).
- Cooldown/full: three drops 1 frame apart with COOLDOWN_FRAMES=1 fill slots 0,1,2; fourth req unacked until a slot retires.
- Bottom retire: bomb at y=478 → next tick inactive (478+3>480); at y=477 → moves to 480, retired on following tick.
- Cannon hit: cannon_gfx=1 while beam over active bomb → next tick cannon_hit pulses exactly one clk, slot cleared.
- Simultaneous: drop_req asserted in tick cycle → no ack that cycle, ack the cycle after.
